// File: rtl/fft.sv
// Streaming radix-2 single-path-delay-feedback FFT, real input, 1/2 scaling per stage.
// Optional natural-order reorder buffer built when FFT_REORDER_EN is defined.
module fft #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_ip,
   input  logic signed [W-1:0] ip,
   output logic [1:0][W-1:0]   op_raw,
   output logic [1:0][W-1:0]   op_shuffled,
   output logic                op_ready
);

   localparam int  L      = 1 << N;
   localparam int  HL     = L / 2;
   localparam int  T0     = L - 1 + N;
   localparam real TWO_PI = 6.283185307179586;
   localparam real SCALE  = 2.0 ** (W - 2);

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   logic signed [W-1:0] tw_re [HL];
   logic signed [W-1:0] tw_im [HL];

   for (genvar k = 0; k < HL; k++) begin : g_tw
      localparam real ANG = TWO_PI * real'(k) / real'(L);
      localparam int  CRE = rnd($cos(ANG) * SCALE);
      localparam int  CIM = rnd(-$sin(ANG) * SCALE);
      assign tw_re[k] = CRE[W-1:0];
      assign tw_im[k] = CIM[W-1:0];
   end

   logic             run_q;
   logic             active;
   logic [N-1:0]     cnt;
   logic [N+1:0]     fill;
   logic             raw_vld;

   assign active = run_q | start_ip;

   // cnt is the frame position of the sample currently on ip; fill times the pipeline latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q   <= 1'b0;
         cnt     <= '0;
         fill    <= '0;
         raw_vld <= 1'b0;
      end else if (active) begin
         run_q <= 1'b1;
         cnt   <= cnt + N'(1);
         if (!raw_vld) begin
            fill <= fill + (N+2)'(1);
            if (fill == (N+2)'(T0 - 1)) raw_vld <= 1'b1;
         end
      end
   end

   logic signed [W-1:0] xre [N+1];
   logic signed [W-1:0] xim [N+1];

   assign xre[0] = ip;
   assign xim[0] = '0;

   for (genvar s = 0; s < N; s++) begin : g_st
      localparam int           D    = 1 << (N - 1 - s);
      localparam int           LAT  = L - (1 << (N - s)) + s;
      localparam logic [N-1:0] LATV = LAT[N-1:0];

      logic [N-1:0]        loc;
      logic                ph;
      logic [N-2:0]        tw_idx;
      logic signed [W-1:0] d_re [D];
      logic signed [W-1:0] d_im [D];
      logic signed [W-1:0] q_re, q_im;
      logic signed [W-1:0] y_re, y_im, din_re, din_im;
      logic signed [W:0]   sum_re, sum_im, dif_re, dif_im;
      logic signed [2*W:0] m_re, m_im;

      // Local frame position of the word entering this stage.
      assign loc    = cnt - LATV;
      assign ph     = loc[N-1-s];
      assign tw_idx = (N-1)'(loc << s);

      always_comb begin
         sum_re = (W+1)'(d_re[D-1]) + (W+1)'(xre[s]);
         sum_im = (W+1)'(d_im[D-1]) + (W+1)'(xim[s]);
         dif_re = (W+1)'(d_re[D-1]) - (W+1)'(xre[s]);
         dif_im = (W+1)'(d_im[D-1]) - (W+1)'(xim[s]);
         m_re   = (2*W+1)'(d_re[D-1]) * (2*W+1)'(tw_re[tw_idx])
                - (2*W+1)'(d_im[D-1]) * (2*W+1)'(tw_im[tw_idx]);
         m_im   = (2*W+1)'(d_re[D-1]) * (2*W+1)'(tw_im[tw_idx])
                + (2*W+1)'(d_im[D-1]) * (2*W+1)'(tw_re[tw_idx]);
         y_re   = W'(m_re >>> (W - 2));
         y_im   = W'(m_im >>> (W - 2));
         din_re = xre[s];
         din_im = xim[s];
         if (ph) begin
            y_re   = sum_re[W:1];
            y_im   = sum_im[W:1];
            din_re = dif_re[W:1];
            din_im = dif_im[W:1];
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            for (int i = 0; i < D; i++) begin
               d_re[i] <= '0;
               d_im[i] <= '0;
            end
            q_re <= '0;
            q_im <= '0;
         end else if (active) begin
            d_re[0] <= din_re;
            d_im[0] <= din_im;
            for (int i = 1; i < D; i++) begin
               d_re[i] <= d_re[i-1];
               d_im[i] <= d_im[i-1];
            end
            q_re <= y_re;
            q_im <= y_im;
         end
      end

      assign xre[s+1] = q_re;
      assign xim[s+1] = q_im;
   end

   assign op_raw = {xre[N], xim[N]};

`ifdef FFT_REORDER_EN
   function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = a[N-1-i];
      return r;
   endfunction

   logic [N-1:0]     pos;
   logic             wbank;
   logic             sh_vld;
   logic [1:0][W-1:0] rbuf [2][L];

   // pos is the bit-reversed slot now on op_raw and also the natural bin being read out.
   assign pos = cnt - N'(N - 1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < L; i++)
               rbuf[b][i] <= '0;
         wbank  <= 1'b0;
         sh_vld <= 1'b0;
      end else if (raw_vld) begin
         rbuf[wbank][bitrev(pos)] <= op_raw;
         if (&pos) begin
            wbank  <= ~wbank;
            sh_vld <= 1'b1;
         end
      end
   end

   assign op_shuffled = sh_vld ? rbuf[~wbank][pos] : '0;
   assign op_ready    = sh_vld;
`else
   assign op_shuffled = op_raw;
   assign op_ready    = raw_vld;
`endif

endmodule

// File: tb/tb_fft.sv
// Directed vector bench for fft (N=4, W=16): impulse, DC, alternating and shifted
// impulse frames streamed back-to-back, plus mid-frame reset and restart.
module tb_fft;
   localparam int N = 4;
   localparam int W = 16;
   localparam int L = 16;
`ifdef FFT_REORDER_EN
   localparam int REORDER = 1;
`else
   localparam int REORDER = 0;
`endif
   localparam int RAW_LAT = L - 1 + N;
   localparam int SH_LAT  = RAW_LAT + REORDER * L;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start_ip = 1'b0;
   logic signed [W-1:0] ip = '0;
   logic [1:0][W-1:0]   op_raw;
   logic [1:0][W-1:0]   op_shuffled;
   logic                op_ready;

   always #5 clk = ~clk;

   fft #(.N(N), .W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start_ip    (start_ip),
      .ip          (ip),
      .op_raw      (op_raw),
      .op_shuffled (op_shuffled),
      .op_ready    (op_ready)
   );

   typedef struct packed {
      logic [L-1:0][15:0] x;
      logic [L-1:0][15:0] er;
      logic [L-1:0][15:0] ei;
      logic [3:0]         tol;
   } vec_t;

   vec_t vt[4];
   int   sel[4];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input int act, input int exp, input int tol);
      total++;
      if (act < exp - tol || act > exp + tol) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", nm, act, exp, tol, $time);
      end
   endtask

   function automatic int br(input int p);
      int r = 0;
      for (int i = 0; i < N; i++) if (p[i]) r |= 1 << (N - 1 - i);
      return r;
   endfunction

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   // Streams nfr frames chosen by sel[], checking op_raw and op_shuffled every cycle.
   // When abort_at >= 0, reset is pulled low in that cycle and the task returns.
   task automatic run_stream(input int nfr, input int abort_at);
      int p, f, v, k;
      for (int c = 0; c < SH_LAT + nfr * L + 2; c++) begin
         @(negedge clk);
         if (c == SH_LAT - 1) chk("ready_before_bin0", int'(op_ready), 0, 0);
         if (c >= RAW_LAT && c < RAW_LAT + nfr * L) begin
            p = (c - RAW_LAT) % L;
            f = (c - RAW_LAT) / L;
            v = sel[f];
            k = br(p);
            chk($sformatf("raw_re f%0d slot%0d", f, p), int'($signed(op_raw[1])),
                int'($signed(vt[v].er[k])), int'(vt[v].tol));
            chk($sformatf("raw_im f%0d slot%0d", f, p), int'($signed(op_raw[0])),
                int'($signed(vt[v].ei[k])), int'(vt[v].tol));
         end
         if (c >= SH_LAT && c < SH_LAT + nfr * L) begin
            p = (c - SH_LAT) % L;
            f = (c - SH_LAT) / L;
            v = sel[f];
            k = (REORDER != 0) ? p : br(p);
            chk($sformatf("shuf_re f%0d pos%0d", f, p), int'($signed(op_shuffled[1])),
                int'($signed(vt[v].er[k])), int'(vt[v].tol));
            chk($sformatf("shuf_im f%0d pos%0d", f, p), int'($signed(op_shuffled[0])),
                int'($signed(vt[v].ei[k])), int'(vt[v].tol));
            chk($sformatf("ready f%0d pos%0d", f, p), int'(op_ready), 1, 0);
         end
         if (c == abort_at) begin
            reset = 1'b0;
            #1;
            chk("abort_raw_re",  int'($signed(op_raw[1])), 0, 0);
            chk("abort_shuf_re", int'($signed(op_shuffled[1])), 0, 0);
            chk("abort_ready",   int'(op_ready), 0, 0);
            start_ip = 1'b0;
            return;
         end
         start_ip = (c == 0);
         if (c < nfr * L) ip = $signed(vt[sel[c / L]].x[c % L]);
         else             ip = '0;
      end
      start_ip = 1'b0;
   endtask

   initial begin
      for (int v = 0; v < 4; v++) vt[v] = '0;
      vt[0].x[0] = 16'h0100;
      vt[0].tol  = 4'd0;
      for (int i = 0; i < L; i++) vt[0].er[i] = 16'h0010;
      for (int i = 0; i < L; i++) vt[1].x[i] = 16'h0100;
      vt[1].er[0] = 16'h0100;
      vt[1].tol   = 4'd1;
      for (int i = 0; i < L; i++) vt[2].x[i] = (i % 2 == 0) ? 16'h0100 : 16'hFF00;
      vt[2].er[8] = 16'h0100;
      vt[2].tol   = 4'd1;
      vt[3].x[1] = 16'h0100;
      vt[3].tol  = 4'd2;
      for (int i = 0; i < L; i++) begin
         vt[3].er[i] = 16'(rnd(16.0 * $cos(6.283185307179586 * i / 16.0)));
         vt[3].ei[i] = 16'(rnd(-16.0 * $sin(6.283185307179586 * i / 16.0)));
      end

      #2 reset = 1'b0;
      #1;
      chk("reset_raw",   int'(op_raw), 0, 0);
      chk("reset_shuf",  int'(op_shuffled), 0, 0);
      chk("reset_ready", int'(op_ready), 0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      sel = '{0, 1, 2, 3};
      run_stream(4, -1);

      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_stream_reset_ready", int'(op_ready), 0, 0);
      chk("post_stream_reset_shuf",  int'(op_shuffled), 0, 0);
      chk("post_stream_reset_raw",   int'(op_raw), 0, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      ip = 16'h0100;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("idle_raw",   int'(op_raw), 0, 0);
         chk("idle_ready", int'(op_ready), 0, 0);
      end

      sel = '{0, 1, 0, 0};
      run_stream(2, 24);
      ip = 16'h0100;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("restart_idle_raw",   int'(op_raw), 0, 0);
         chk("restart_idle_ready", int'(op_ready), 0, 0);
      end

      sel = '{2, 0, 0, 0};
      run_stream(1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
